// File: rtl/ads1292_pkg.sv
// Shared encodings and helpers for the ADS1292 SPI transaction sequencer.
// Covers command types, opcode bases, FSM states and per-command byte selection.
package ads1292_pkg;

    typedef enum logic [1:0] {
        CMD_OPCODE      = 2'd0,
        CMD_RREG        = 2'd1,
        CMD_WREG        = 2'd2,
        CMD_RDATA_FRAME = 2'd3
    } cmd_type_t;

    typedef enum logic [2:0] {
        ST_IDLE_WAIT,
        ST_IDLE,
        ST_SETUP,
        ST_SEND,
        ST_WAIT_RX,
        ST_GAP,
        ST_HOLD
    } seq_state_t;

    localparam logic [7:0]  RREG_BASE   = 8'h20;
    localparam logic [7:0]  WREG_BASE   = 8'h40;
    localparam int unsigned FRAME_BYTES = 9;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic [3:0] cmd_byte_count(input cmd_type_t t);
        logic [3:0] n;
        case (t)
            CMD_OPCODE:      n = 4'd1;
            CMD_RREG:        n = 4'd3;
            CMD_WREG:        n = 4'd3;
            CMD_RDATA_FRAME: n = 4'(FRAME_BYTES);
            default:         n = 4'd1;
        endcase
        return n;
    endfunction

    // Bytes are chosen by the remaining count: 3 = first byte of a register access, 1 = last.
    function automatic logic [7:0] cmd_tx_byte(input cmd_type_t t, input logic [3:0] rem,
                                               input logic [7:0] op, input logic [4:0] addr,
                                               input logic [7:0] data);
        logic [7:0] b;
        b = 8'h00;
        case (t)
            CMD_OPCODE: b = op;
            CMD_RREG:   if (rem == 4'd3) b = RREG_BASE | {3'b000, addr};
            CMD_WREG: begin
                if (rem == 4'd3)      b = WREG_BASE | {3'b000, addr};
                else if (rem == 4'd1) b = data;
            end
            default:    b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/seq_delay_counter.sv
// Loadable down-counter with a zero flag, shared by every timed phase of the sequencer.
module seq_delay_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Load,
    input  logic [WIDTH-1:0] i_Load_Val,
    input  logic             i_Dec,
    output logic             o_Zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt <= '0;
        end else if (i_Load) begin
            cnt <= i_Load_Val;
        end else if (i_Dec && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    always_comb begin
        o_Zero = (cnt == '0);
    end

endmodule

// File: rtl/ads1292_spi_sequencer.sv
// Turns one host command into a CS-framed multi-byte SPI transaction for the ADS1292,
// driving the byte engine and assembling received bytes into register/frame results.
module ads1292_spi_sequencer
    import ads1292_pkg::*;
#(
    parameter int unsigned CS_SETUP_CLKS   = 4,
    parameter int unsigned INTER_BYTE_CLKS = 8,
    parameter int unsigned CS_HOLD_CLKS    = 4,
    parameter int unsigned CS_IDLE_CLKS    = 4
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        i_Cmd_Valid,
    input  logic [1:0]  i_Cmd_Type,
    input  logic [7:0]  i_Cmd_Op,
    input  logic [4:0]  i_Reg_Addr,
    input  logic [7:0]  i_Reg_Data,
    output logic        o_Cmd_Ready,
    output logic        o_Done,
    output logic [7:0]  o_Reg_Rd,
    output logic [71:0] o_Frame,
    output logic        o_Frame_DV,
    output logic [7:0]  o_TX_Byte,
    output logic        o_TX_DV,
    input  logic        i_TX_Ready,
    input  logic        i_RX_DV,
    input  logic [7:0]  i_RX_Byte,
    output logic        o_SPI_CS_n
);

    localparam int unsigned MAX_CLKS = max4(CS_SETUP_CLKS, INTER_BYTE_CLKS, CS_HOLD_CLKS, CS_IDLE_CLKS);
    localparam int unsigned CW       = (MAX_CLKS > 1) ? $clog2(MAX_CLKS) : 1;

    // Each timed state lasts N cycles: the counter is loaded with N-1 on entry.
    localparam logic [CW-1:0] SETUP_LOAD = CW'(CS_SETUP_CLKS - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'((INTER_BYTE_CLKS > 0) ? INTER_BYTE_CLKS - 1 : 0);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(CS_HOLD_CLKS - 1);
    localparam logic [CW-1:0] IDLE_LOAD  = CW'(CS_IDLE_CLKS - 1);

    seq_state_t    state, next_state;
    cmd_type_t     cmd_type_q;
    logic [7:0]    op_q;
    logic [4:0]    addr_q;
    logic [7:0]    data_q;
    logic [3:0]    rem_q;
    logic [71:0]   rx_sr;

    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic          cnt_dec;
    logic          cnt_zero;
    logic          accept;
    logic          tx_fire;
    logic          rx_take;
    logic          xfer_end;

    seq_delay_counter #(.WIDTH(CW)) u_delay (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Load     (cnt_load),
        .i_Load_Val (cnt_load_val),
        .i_Dec      (cnt_dec),
        .o_Zero     (cnt_zero)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= ST_IDLE_WAIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        accept       = 1'b0;
        tx_fire      = 1'b0;
        rx_take      = 1'b0;
        xfer_end     = 1'b0;
        case (state)
            ST_IDLE_WAIT: begin
                if (cnt_zero) next_state = ST_IDLE;
                else          cnt_dec    = 1'b1;
            end
            ST_IDLE: begin
                if (i_Cmd_Valid) begin
                    accept       = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = SETUP_LOAD;
                    next_state   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) next_state = ST_SEND;
                else          cnt_dec    = 1'b1;
            end
            ST_SEND: begin
                if (i_TX_Ready) begin
                    tx_fire    = 1'b1;
                    next_state = ST_WAIT_RX;
                end
            end
            ST_WAIT_RX: begin
                if (i_RX_DV) begin
                    rx_take = 1'b1;
                    if (rem_q == 4'd1) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = HOLD_LOAD;
                        next_state   = ST_HOLD;
                    end else if (INTER_BYTE_CLKS == 0) begin
                        next_state = ST_SEND;
                    end else begin
                        cnt_load     = 1'b1;
                        cnt_load_val = GAP_LOAD;
                        next_state   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_zero) next_state = ST_SEND;
                else          cnt_dec    = 1'b1;
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    xfer_end     = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = IDLE_LOAD;
                    next_state   = ST_IDLE_WAIT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: next_state = ST_IDLE_WAIT;
        endcase
    end

    // CS is decoded from the state register so an asynchronous reset raises it at once.
    always_comb begin
        o_Cmd_Ready = (state == ST_IDLE);
        o_SPI_CS_n  = (state == ST_IDLE_WAIT) || (state == ST_IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cmd_type_q <= CMD_OPCODE;
            op_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rem_q      <= '0;
            rx_sr      <= '0;
            o_TX_Byte  <= '0;
            o_TX_DV    <= 1'b0;
            o_Done     <= 1'b0;
            o_Frame_DV <= 1'b0;
            o_Reg_Rd   <= '0;
            o_Frame    <= '0;
        end else begin
            o_TX_DV    <= tx_fire;
            o_Done     <= xfer_end;
            o_Frame_DV <= xfer_end && (cmd_type_q == CMD_RDATA_FRAME);
            if (accept) begin
                cmd_type_q <= cmd_type_t'(i_Cmd_Type);
                op_q       <= i_Cmd_Op;
                addr_q     <= i_Reg_Addr;
                data_q     <= i_Reg_Data;
                rem_q      <= cmd_byte_count(cmd_type_t'(i_Cmd_Type));
            end
            if (tx_fire) begin
                o_TX_Byte <= cmd_tx_byte(cmd_type_q, rem_q, op_q, addr_q, data_q);
            end
            if (rx_take) begin
                rx_sr <= {rx_sr[63:0], i_RX_Byte};
                rem_q <= rem_q - 4'd1;
            end
            // Results are published only when the transaction closes, keeping them stable meanwhile.
            if (xfer_end) begin
                if (cmd_type_q == CMD_RREG)        o_Reg_Rd <= rx_sr[7:0];
                if (cmd_type_q == CMD_RDATA_FRAME) o_Frame  <= rx_sr;
            end
        end
    end

endmodule

// File: tb/tb_ads1292_spi_sequencer.sv
// Directed bench for the ADS1292 SPI sequencer with a simple SPI byte-engine/MISO model.
module tb_ads1292_spi_sequencer;

    localparam int unsigned CS_SETUP = 4;
    localparam int unsigned GAP      = 8;
    localparam int unsigned HOLD     = 4;
    localparam int unsigned IDLE     = 4;

    logic        i_Clk = 1'b0;
    logic        i_Rst_L;
    logic        i_Cmd_Valid;
    logic [1:0]  i_Cmd_Type;
    logic [7:0]  i_Cmd_Op;
    logic [4:0]  i_Reg_Addr;
    logic [7:0]  i_Reg_Data;
    logic        o_Cmd_Ready;
    logic        o_Done;
    logic [7:0]  o_Reg_Rd;
    logic [71:0] o_Frame;
    logic        o_Frame_DV;
    logic [7:0]  o_TX_Byte;
    logic        o_TX_DV;
    logic        i_TX_Ready = 1'b1;
    logic        i_RX_DV    = 1'b0;
    logic [7:0]  i_RX_Byte  = 8'h00;
    logic        o_SPI_CS_n;

    always #5 i_Clk = ~i_Clk;

    ads1292_spi_sequencer #(
        .CS_SETUP_CLKS   (CS_SETUP),
        .INTER_BYTE_CLKS (GAP),
        .CS_HOLD_CLKS    (HOLD),
        .CS_IDLE_CLKS    (IDLE)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_Cmd_Valid (i_Cmd_Valid),
        .i_Cmd_Type  (i_Cmd_Type),
        .i_Cmd_Op    (i_Cmd_Op),
        .i_Reg_Addr  (i_Reg_Addr),
        .i_Reg_Data  (i_Reg_Data),
        .o_Cmd_Ready (o_Cmd_Ready),
        .o_Done      (o_Done),
        .o_Reg_Rd    (o_Reg_Rd),
        .o_Frame     (o_Frame),
        .o_Frame_DV  (o_Frame_DV),
        .o_TX_Byte   (o_TX_Byte),
        .o_TX_DV     (o_TX_DV),
        .i_TX_Ready  (i_TX_Ready),
        .i_RX_DV     (i_RX_DV),
        .i_RX_Byte   (i_RX_Byte),
        .o_SPI_CS_n  (o_SPI_CS_n)
    );

    int          checks = 0;
    int          errors = 0;

    int          cyc = 0, tx_cnt = 0, rx_idx = 0, busy = 0;
    int          done_cnt = 0, fdv_cnt = 0, cs_fall_cnt = 0;
    int          t_cs_fall = 0, t_cs_rise = 0, t_ready = 0;
    logic        prev_cs = 1'b1, prev_ready = 1'b0;
    logic [7:0]  tx_log [128];
    int          tx_time [128];
    int          rx_time [128];
    logic [7:0]  miso [128];

    // SPI engine model: answers each TX_DV with an RX_DV four cycles later, from the MISO table.
    always @(negedge i_Clk) begin
        cyc++;
        if (prev_cs && !o_SPI_CS_n) begin cs_fall_cnt++; t_cs_fall = cyc; end
        if (!prev_cs && o_SPI_CS_n) t_cs_rise = cyc;
        if (!prev_ready && o_Cmd_Ready) t_ready = cyc;
        prev_cs    = o_SPI_CS_n;
        prev_ready = o_Cmd_Ready;
        if (o_Done)     done_cnt++;
        if (o_Frame_DV) fdv_cnt++;
        i_RX_DV = 1'b0;
        if (!i_Rst_L) begin
            busy       = 0;
            i_TX_Ready = 1'b1;
            rx_idx     = tx_cnt;
        end else if (o_TX_DV) begin
            tx_log[tx_cnt % 128]  = o_TX_Byte;
            tx_time[tx_cnt % 128] = cyc;
            tx_cnt++;
            busy       = 4;
            i_TX_Ready = 1'b0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                i_RX_DV               = 1'b1;
                i_RX_Byte             = miso[rx_idx % 128];
                rx_time[rx_idx % 128] = cyc;
                rx_idx++;
                i_TX_Ready            = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge i_Clk); #1;
        while (o_Cmd_Ready !== 1'b1 && n < 200) begin @(negedge i_Clk); #1; n++; end
        chk({tag, "_ready_wait"}, 72'(n < 200), 72'd1);
    endtask

    task automatic issue(input logic [1:0] t, input logic [7:0] op, input logic [4:0] a, input logic [7:0] d);
        wait_ready("issue");
        i_Cmd_Valid = 1'b1;
        i_Cmd_Type  = t;
        i_Cmd_Op    = op;
        i_Reg_Addr  = a;
        i_Reg_Data  = d;
        @(negedge i_Clk); #1;
        i_Cmd_Valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge i_Clk); #1;
        while (o_Done !== 1'b1 && n < 1000) begin @(negedge i_Clk); #1; n++; end
        chk({tag, "_done_wait"}, 72'(n < 1000), 72'd1);
    endtask

    initial begin
        int          b_tx, b_rx, b_done, b_fall, n;
        logic [7:0]  acc;
        logic [71:0] fexp;

        for (int i = 0; i < 128; i++) miso[i] = 8'h00;
        i_Rst_L     = 1'b0;
        i_Cmd_Valid = 1'b0;
        i_Cmd_Type  = 2'd0;
        i_Cmd_Op    = 8'h00;
        i_Reg_Addr  = 5'h00;
        i_Reg_Data  = 8'h00;
        repeat (3) @(negedge i_Clk);
        #1;
        chk("rst_ready",    72'(o_Cmd_Ready), 72'd0);
        chk("rst_cs_n",     72'(o_SPI_CS_n),  72'd1);
        chk("rst_tx_dv",    72'(o_TX_DV),     72'd0);
        chk("rst_tx_byte",  72'(o_TX_Byte),   72'd0);
        chk("rst_done",     72'(o_Done),      72'd0);
        chk("rst_frame_dv", 72'(o_Frame_DV),  72'd0);
        chk("rst_reg_rd",   72'(o_Reg_Rd),    72'd0);
        chk("rst_frame",    o_Frame,          72'd0);
        i_Rst_L = 1'b1;

        // OPCODE START
        b_tx = tx_cnt; b_done = done_cnt;
        issue(2'd0, 8'h08, 5'h00, 8'h00);
        wait_done("op");
        chk("op_frame_dv",   72'(o_Frame_DV), 72'd0);
        chk("op_cs_at_done", 72'(o_SPI_CS_n), 72'd1);
        chk("op_tx_count",   72'(tx_cnt - b_tx), 72'd1);
        chk("op_tx_byte",    72'(tx_log[b_tx]), 72'h08);
        chk("op_cs_setup",   72'((tx_time[b_tx] - t_cs_fall) >= int'(CS_SETUP)), 72'd1);
        chk("op_cs_hold",    72'((t_cs_rise - rx_time[b_tx] - 1) >= int'(HOLD)), 72'd1);
        wait_ready("op_idle");
        chk("op_idle_gap",   72'((t_ready - t_cs_rise) >= int'(IDLE)), 72'd1);
        chk("op_done_count", 72'(done_cnt - b_done), 72'd1);

        // WREG addr 0x01 data 0x02
        b_tx = tx_cnt; b_fall = cs_fall_cnt;
        issue(2'd2, 8'h00, 5'h01, 8'h02);
        wait_done("wreg");
        chk("wreg_tx_count", 72'(tx_cnt - b_tx), 72'd3);
        chk("wreg_byte0",    72'(tx_log[b_tx]),     72'h41);
        chk("wreg_byte1",    72'(tx_log[b_tx + 1]), 72'h00);
        chk("wreg_byte2",    72'(tx_log[b_tx + 2]), 72'h02);
        chk("wreg_gap1",     72'((tx_time[b_tx + 1] - rx_time[b_tx] - 1) >= int'(GAP)), 72'd1);
        chk("wreg_gap2",     72'((tx_time[b_tx + 2] - rx_time[b_tx + 1] - 1) >= int'(GAP)), 72'd1);
        chk("wreg_cs_cont",  72'(cs_fall_cnt - b_fall), 72'd1);

        // RREG addr 0x00, third MISO byte 0x73
        wait_ready("rreg_pre");
        b_tx = tx_cnt; b_rx = rx_idx;
        miso[b_rx] = 8'hEE; miso[b_rx + 1] = 8'h11; miso[b_rx + 2] = 8'h73;
        issue(2'd1, 8'h00, 5'h00, 8'h00);
        wait_done("rreg");
        chk("rreg_reg_rd",   72'(o_Reg_Rd),   72'h73);
        chk("rreg_frame_dv", 72'(o_Frame_DV), 72'd0);
        chk("rreg_byte0",    72'(tx_log[b_tx]), 72'h20);
        chk("rreg_tx_count", 72'(tx_cnt - b_tx), 72'd3);

        // RDATA_FRAME
        wait_ready("frame_pre");
        b_tx = tx_cnt; b_rx = rx_idx;
        fexp = 72'hC00000123456ABCDEF;
        for (int i = 0; i < 9; i++) miso[b_rx + i] = fexp[71 - 8*i -: 8];
        issue(2'd3, 8'h00, 5'h00, 8'h00);
        wait_done("frame");
        chk("frame_value",    o_Frame, fexp);
        chk("frame_dv",       72'(o_Frame_DV), 72'd1);
        chk("frame_tx_count", 72'(tx_cnt - b_tx), 72'd9);
        acc = 8'h00;
        for (int i = 0; i < 9; i++) acc = acc | tx_log[b_tx + i];
        chk("frame_tx_zero",  72'(acc), 72'h00);
        chk("frame_reg_keep", 72'(o_Reg_Rd), 72'h73);

        // Valid held high with changing fields during a busy WREG
        wait_ready("busy_pre");
        b_tx = tx_cnt;
        i_Cmd_Valid = 1'b1; i_Cmd_Type = 2'd2; i_Cmd_Op = 8'h00; i_Reg_Addr = 5'h05; i_Reg_Data = 8'hA5;
        @(negedge i_Clk); #1;
        i_Cmd_Type = 2'd0; i_Cmd_Op = 8'hFF; i_Reg_Addr = 5'h1F; i_Reg_Data = 8'h3C;
        wait_done("busy_wreg");
        chk("busy_tx_count", 72'(tx_cnt - b_tx), 72'd3);
        chk("busy_byte0",    72'(tx_log[b_tx]),     72'h45);
        chk("busy_byte1",    72'(tx_log[b_tx + 1]), 72'h00);
        chk("busy_byte2",    72'(tx_log[b_tx + 2]), 72'hA5);
        wait_ready("busy_next");
        @(negedge i_Clk); #1;
        i_Cmd_Valid = 1'b0;
        chk("busy_idle_wait", 72'((t_cs_fall - t_cs_rise) >= int'(IDLE)), 72'd1);
        wait_done("busy_op");
        chk("busy_op_count", 72'(tx_cnt - b_tx), 72'd4);
        chk("busy_op_byte",  72'(tx_log[b_tx + 3]), 72'hFF);

        // Reset in the middle of a frame read
        wait_ready("rst_pre");
        b_rx = rx_idx; b_done = done_cnt;
        issue(2'd3, 8'h00, 5'h00, 8'h00);
        n = 0;
        while (rx_idx < b_rx + 5 && n < 500) begin @(negedge i_Clk); #1; n++; end
        chk("mid_rx5_wait", 72'(n < 500), 72'd1);
        @(negedge i_Clk); #2;
        i_Rst_L = 1'b0;
        #1;
        chk("mid_cs_async", 72'(o_SPI_CS_n),  72'd1);
        chk("mid_frame",    o_Frame,          72'd0);
        chk("mid_reg_rd",   72'(o_Reg_Rd),    72'd0);
        chk("mid_ready",    72'(o_Cmd_Ready), 72'd0);
        repeat (2) @(negedge i_Clk);
        #1;
        i_Rst_L = 1'b1;
        repeat (3) @(negedge i_Clk);
        #1;
        chk("mid_no_done",  72'(done_cnt - b_done), 72'd0);
        b_tx = tx_cnt;
        issue(2'd0, 8'h0A, 5'h00, 8'h00);
        wait_done("post_rst");
        chk("post_tx_count", 72'(tx_cnt - b_tx), 72'd1);
        chk("post_tx_byte",  72'(tx_log[b_tx]), 72'h0A);
        chk("post_done_cnt", 72'(done_cnt - b_done), 72'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ads1292_spi_sequencer.md
Name: ads1292_spi_sequencer

Overview:
Transaction controller that sequences the byte-level SPI master for the ADS1292 front end. It turns one host command into a complete chip-select-framed, multi-byte SPI transaction. Supported commands are a single opcode, a register read (RREG), a register write (WREG), or a 9-byte data-frame read. It owns CS timing, inter-byte gaps and the assembly of received bytes. It sits between the sensor control FSM and the SPI byte engine.

Parameters:
CS_SETUP_CLKS, 4, i_Clk cycles from CS low to first TX_DV (min 1)
INTER_BYTE_CLKS, 8, idle i_Clk cycles between RX_DV of one byte and TX_DV of the next (min 0)
CS_HOLD_CLKS, 4, i_Clk cycles from last RX_DV to CS high (min 1)
CS_IDLE_CLKS, 4, minimum CS-high cycles before the next command is accepted (min 1)

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  reset, asynchronous, active-low
i_Cmd_Valid  in  1  command request, accepted when o_Cmd_Ready=1
i_Cmd_Type  in  2  0=OPCODE, 1=RREG, 2=WREG, 3=RDATA_FRAME
i_Cmd_Op  in  8  opcode byte (OPCODE type only)
i_Reg_Addr  in  5  register address (RREG/WREG)
i_Reg_Data  in  8  write data (WREG)
o_Cmd_Ready  out  1  idle, able to accept a command
o_Done  out  1  one-cycle pulse when a transaction completes (after CS high)
o_Reg_Rd  out  8  RREG result, valid from o_Done until the next RREG completes
o_Frame  out  72  RDATA_FRAME result (status[71:48], ch1[47:24], ch2[23:0]), first byte in [71:64]
o_Frame_DV  out  1  one-cycle pulse coincident with o_Done for RDATA_FRAME
o_TX_Byte  out  8  byte to SPI master
o_TX_DV  out  1  one-cycle load pulse to SPI master
i_TX_Ready  in  1  SPI master idle
i_RX_DV  in  1  SPI master byte-received pulse
i_RX_Byte  in  8  received byte
o_SPI_CS_n  out  1  ADS1292 chip select, active-low

Behaviour:
- Reset values: o_Cmd_Ready=0, o_SPI_CS_n=1, o_TX_DV=0, o_TX_Byte=0, o_Done=0, o_Frame_DV=0, o_Reg_Rd=0, o_Frame=0, FSM=IDLE_WAIT with the idle counter cleared.
- Reset mid-transaction: CS goes high asynchronously and the partial transaction is discarded.
- States:
  - IDLE_WAIT: hold CS high for CS_IDLE_CLKS, then go to IDLE.
  - IDLE: o_Cmd_Ready=1. When i_Cmd_Valid=1, latch all command fields, set the byte count, go to SETUP. o_Cmd_Ready drops the next cycle.
  - SETUP: CS low; after CS_SETUP_CLKS go to SEND.
  - SEND: wait for i_TX_Ready=1, then pulse o_TX_DV for exactly 1 cycle with the current byte; go to WAIT_RX.
  - WAIT_RX: on i_RX_DV, store i_RX_Byte and decrement the remaining count. If remaining=0 go to HOLD; otherwise go to GAP.
  - GAP: wait INTER_BYTE_CLKS cycles (skip if 0), then go to SEND.
  - HOLD: after CS_HOLD_CLKS, CS high; pulse o_Done (and o_Frame_DV for RDATA_FRAME); go to IDLE_WAIT.
- Byte sequences:
  - OPCODE: 1 byte, i_Cmd_Op.
  - RREG: 3 bytes: 0x20|addr, 0x00, 0x00. The third received byte goes to o_Reg_Rd.
  - WREG: 3 bytes: 0x40|addr, 0x00, data.
  - RDATA_FRAME: 9 bytes of 0x00. Received bytes shift into o_Frame MSB-first. The RDATAC opcode is issued separately by the host.
- Byte counter is 4 bits. The delay counter is sized to the maximum of all timing parameters.
- i_Cmd_Valid while not ready is ignored; there is no queuing.
- A stray i_RX_DV outside WAIT_RX is ignored.
- o_Reg_Rd and o_Frame are updated only at o_Done, so they stay stable during a transaction.

Decomposition:
- Package ads1292_pkg holds the command-type encodings (CMD_OPCODE, CMD_RREG, CMD_WREG, CMD_RDATA_FRAME), the opcode bases (RREG_BASE=0x20, WREG_BASE=0x40), FRAME_BYTES=9, and the FSM state encoding.
- One sub-module, seq_delay_counter: a loadable down-counter with a zero flag, reused for setup, gap, hold and idle.

Test Plan:
- OPCODE 0x08 (START) -> one TX_DV with 0x08. CS low ≥4 cycles before TX_DV and ≥4 after RX_DV. One o_Done pulse; o_Cmd_Ready returns after 4 idle cycles.
- WREG addr 0x01, data 0x02 -> TX bytes 0x41, 0x00, 0x02. Each gap ≥8 cycles from RX_DV to the next TX_DV. CS is continuous low across all 3 bytes.
- RREG addr 0x00, MISO model returns 0x73 on byte 3 -> o_Reg_Rd=0x73 at o_Done, no o_Frame_DV.
- RDATA_FRAME, MISO bytes 0xC0,0x00,0x00,0x12,0x34,0x56,0xAB,0xCD,0xEF -> o_Frame=0xC00000123456ABCDEF with o_Frame_DV and o_Done on the same cycle; 9 TX_DV pulses, all 0x00.
- i_Cmd_Valid held high during a busy WREG with different fields -> no extra bytes; the next command is accepted only after IDLE_WAIT.
- Assert i_Rst_L low after byte 5 of RDATA_FRAME -> CS high immediately, no o_Done, o_Frame=0; after release a new OPCODE completes normally.
